rs_syndrome_calc: RTL and testbench



---
 rtl/rs_pkg.sv | 37 +++
 rtl/gf2_4_mult_const.sv | 20 ++
 rtl/rs_syndrome_calc.sv | 111 +++++++++++
 tb/tb_rs_syndrome_calc.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  rs_pkg : shared GF(2^4) types, constants and multiply helper for RS(15,9)
//  Revision: 1.0
// ============================================================================
package rs_pkg;

    localparam int WORD_WIDTH = 4;
    localparam int NUM_NK     = 6;
    localparam int N_SYM      = 15;

    typedef logic [WORD_WIDTH-1:0] gf_t;

    // x^4 + x + 1
    localparam logic [WORD_WIDTH:0] PRIM_POLY = 5'h13;

    localparam gf_t ALPHA_POW [0:14] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    // Shift-and-add product; with one constant operand this folds to XORs.
    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        gf_t p;
        gf_t x;
        p = '0;
        x = a;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[WORD_WIDTH-2:0], 1'b0} ^
                (x[WORD_WIDTH-1] ? PRIM_POLY[WORD_WIDTH-1:0] : gf_t'(0));
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf2_4_mult_const.sv
`default_nettype none
// ============================================================================
//  gf2_4_mult_const : combinational multiply by the constant alpha^EXP
//  Revision: 1.0
// ============================================================================
module gf2_4_mult_const
    import rs_pkg::*;
#(
    parameter int EXP = 1
) (
    input  gf_t a_i,
    output gf_t p_o
);

    localparam gf_t C_FACTOR = ALPHA_POW[EXP % N_SYM];

    assign p_o = gf_mul(a_i, C_FACTOR);

endmodule
`default_nettype wire

// File: rtl/rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  rs_syndrome_calc : serial Horner syndrome calculator, RS(15,9) over GF(2^4)
//  Optional macro RS_SYN_ZERO_FLAG_EN adds the syn_zero output.
//  Revision: 1.0
// ============================================================================
module rs_syndrome_calc
    import rs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sym_valid,
    input  logic sof,
    input  gf_t  sym_in,
    output gf_t  syndrom [NUM_NK],
    output logic rdy,
    output logic sync_err
`ifdef RS_SYN_ZERO_FLAG_EN
    ,
    output logic syn_zero
`endif
);

    localparam int CNT_W = $clog2(N_SYM);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_SYM - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    gf_t              acc_q      [NUM_NK];
    gf_t              acc_d      [NUM_NK];
    gf_t              syndrom_q  [NUM_NK];
    logic             rdy_q;
    logic             sync_err_q;

    for (genvar j = 0; j < NUM_NK; j++) begin : g_root
        gf_t prod_w;
        gf2_4_mult_const #(.EXP(j + 1)) u_mul (
            .a_i (acc_q[j]),
            .p_o (prod_w)
        );
        assign acc_d[j] = prod_w ^ sym_in;
    end

`ifdef RS_SYN_ZERO_FLAG_EN
    logic syn_zero_q;
    logic all_zero_d;

    always_comb begin
        all_zero_d = 1'b1;
        for (int j = 0; j < NUM_NK; j++) begin
            if (acc_d[j] != '0) all_zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syn_zero_q <= 1'b0;
        end else if (sym_valid && !sof && state_q == ACCUM && cnt_q == C_LAST) begin
            syn_zero_q <= all_zero_d;
        end
    end

    assign syn_zero = syn_zero_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
            sync_err_q <= 1'b0;
            for (int j = 0; j < NUM_NK; j++) begin
                acc_q[j]     <= '0;
                syndrom_q[j] <= '0;
            end
        end else begin
            sync_err_q <= 1'b0;
            if (sym_valid) begin
                if (sof) begin
                    // A first symbol while accumulating means the previous word was truncated.
                    for (int j = 0; j < NUM_NK; j++) acc_q[j] <= sym_in;
                    cnt_q      <= CNT_W'(1);
                    state_q    <= ACCUM;
                    rdy_q      <= 1'b0;
                    sync_err_q <= (state_q == ACCUM);
                end else if (state_q == IDLE) begin
                    sync_err_q <= 1'b1;
                end else begin
                    for (int j = 0; j < NUM_NK; j++) acc_q[j] <= acc_d[j];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        for (int j = 0; j < NUM_NK; j++) syndrom_q[j] <= acc_d[j];
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

    assign syndrom  = syndrom_q;
    assign rdy      = rdy_q;
    assign sync_err = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  tb_rs_syndrome_calc : directed, table-driven bench for rs_syndrome_calc
//  Revision: 1.0
// ============================================================================
module tb_rs_syndrome_calc;
    import rs_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sym_valid = 1'b0;
    logic sof = 1'b0;
    gf_t  sym_in = '0;
    gf_t  syndrom [NUM_NK];
    logic rdy;
    logic sync_err;
`ifdef RS_SYN_ZERO_FLAG_EN
    logic syn_zero;
`endif

    always #5 clk = ~clk;

    rs_syndrome_calc dut (
        .clk       (clk),
        .rst       (rst),
        .sym_valid (sym_valid),
        .sof       (sof),
        .sym_in    (sym_in),
        .syndrom   (syndrom),
        .rdy       (rdy),
        .sync_err  (sync_err)
`ifdef RS_SYN_ZERO_FLAG_EN
        ,
        .syn_zero  (syn_zero)
`endif
    );

    typedef struct packed {
        logic [14:0][3:0] syms;   // syms[i] = r_i
        logic [5:0][3:0]  exp;    // exp[j]  = S_j
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;
    int   se_cnt = 0;
    int   rdy_hi_cnt = 0;

    always @(negedge clk) begin
        if (sync_err === 1'b1) se_cnt++;
        if (rdy === 1'b1) rdy_hi_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [14:0][3:0] syms, input bit gaps);
        for (int i = 14; i >= 0; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    sym_valid = 1'b0;
                    sof = 1'b0;
                    @(posedge clk); #1;
                end
            end
            sym_valid = 1'b1;
            sof = (i == 14);
            sym_in = syms[i];
            if (i == 0) chk("rdy_before_last", 32'(rdy), 32'd0);
            @(posedge clk); #1;
            if (i == 14) chk("rdy_low_after_sof", 32'(rdy), 32'd0);
        end
        sym_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [5:0][3:0] exp);
        chk({name, "_rdy"}, 32'(rdy), 32'd1);
        for (int j = 0; j < NUM_NK; j++)
            chk($sformatf("%s_S%0d", name, j), 32'(syndrom[j]), 32'(exp[j]));
`ifdef RS_SYN_ZERO_FLAG_EN
        chk({name, "_syn_zero"}, 32'(syn_zero), 32'(exp == '0));
`endif
    endtask

    initial begin
        int se0;
        int rh0;

        vecs[0] = '{syms: 60'h000000000000000, exp: 24'h000000};
        vecs[1] = '{syms: 60'h000000000000001, exp: 24'h111111};
        vecs[2] = '{syms: 60'h100000000000000, exp: 24'hA7EFD9};
        vecs[3] = '{syms: 60'h000000000000010, exp: 24'hC63842};
        vecs[4] = '{syms: 60'h000000000000015, exp: 24'h936D17};
        vecs[5] = '{syms: 60'h100000000000001, exp: 24'hB6FEC8};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_sync_err", 32'(sync_err), 32'd0);
        for (int j = 0; j < NUM_NK; j++)
            chk($sformatf("reset_S%0d", j), 32'(syndrom[j]), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back table vectors
        se0 = se_cnt;
        for (int k = 0; k < 6; k++) begin
            send_word(vecs[k].syms, 1'b0);
            check_result($sformatf("vec%0d", k), vecs[k].exp);
        end
        chk("no_sync_err_clean", 32'(se_cnt - se0), 32'd0);

        // r_14 = 1 with random gaps; rdy/syndromes held while idle
        send_word(vecs[2].syms, 1'b1);
        check_result("gaps", vecs[2].exp);
        repeat (3) @(posedge clk);
        #1;
        chk("rdy_held_idle", 32'(rdy), 32'd1);
        chk("S0_held_idle", 32'(syndrom[0]), 32'h9);

        // Restart: sof again at symbol 7, then a full zero word
        se0 = se_cnt;
        sym_valid = 1'b1; sof = 1'b1; sym_in = 4'h3;
        @(posedge clk); #1;
        sof = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("rdy_low_partial", 32'(rdy), 32'd0);
        send_word(vecs[0].syms, 1'b0);
        check_result("restart", vecs[0].exp);
        @(posedge clk); #1;
        chk("restart_sync_err_once", 32'(se_cnt - se0), 32'd1);

        // Async reset mid-word after a nonzero result, then orphan symbols
        send_word(vecs[5].syms, 1'b0);
        check_result("pre_rst", vecs[5].exp);
        sym_valid = 1'b1; sof = 1'b1; sym_in = 4'h1;
        @(posedge clk); #1;
        sof = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        sym_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_rdy", 32'(rdy), 32'd0);
        for (int j = 0; j < NUM_NK; j++)
            chk($sformatf("async_rst_S%0d", j), 32'(syndrom[j]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        se0 = se_cnt;
        rh0 = rdy_hi_cnt;
        sym_valid = 1'b1; sof = 1'b0; sym_in = 4'h7;
        repeat (15) begin @(posedge clk); #1; end
        sym_valid = 1'b0;
        @(posedge clk); #1;
        chk("orphan_sync_err_count", 32'(se_cnt - se0), 32'd15);
        chk("orphan_no_rdy", 32'(rdy_hi_cnt - rh0), 32'd0);
        chk("orphan_sync_err_clear", 32'(sync_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
